osc_gate_ctrl: RTL



---
 rtl/osc_gate_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/osc_gate_ctrl.sv
// Gate/latch scheduler for NUM_CH ring-oscillator counters; emits one sample frame per gate.
// Define OSC_GATE_SEQ_EN to add the smp_seq frame sequence number output.
module osc_gate_ctrl #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned GATE_CYCLES = 10_000_000,
  parameter int unsigned RUN_SAMPLES = 30,
  parameter int unsigned HALT_GATES  = 1,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                      ref_clk,
  input  logic                      arst_n,
  input  logic                      enable,
  output logic                      osc_rst,
  output logic                      osc_halt,
  output logic                      osc_latch_req,
  input  logic [NUM_CH-1:0]         osc_latch_ack,
  input  logic [NUM_CH*CNT_W-1:0]   osc_count,
  output logic                      smp_valid,
  input  logic                      smp_ready,
  output logic [NUM_CH*CNT_W-1:0]   smp_data,
  output logic [NUM_CH-1:0]         smp_ch_ok,
  output logic [7:0]                smp_drops
`ifdef OSC_GATE_SEQ_EN
  ,
  output logic [15:0]               smp_seq
`endif
);

  localparam int unsigned DATA_W      = NUM_CH * CNT_W;
  localparam int unsigned HALT_CYCLES = HALT_GATES * GATE_CYCLES;
  localparam int unsigned MAX_GH      = (GATE_CYCLES > HALT_CYCLES) ? GATE_CYCLES : HALT_CYCLES;
  localparam int unsigned TMR_MAX     = (MAX_GH > ACK_TIMEOUT) ? MAX_GH : ACK_TIMEOUT;
  localparam int unsigned TMR_W       = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned SMP_W       = (RUN_SAMPLES > 0) ? $clog2(RUN_SAMPLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_GATE, S_REQ, S_REL, S_PUSH, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [SMP_W-1:0]    samples_q, samples_d;
  logic [NUM_CH-1:0]   ack_meta_q, ack_sync_q;
  logic [DATA_W-1:0]   cap_data_q, cap_d;
  logic [NUM_CH-1:0]   cap_ok_q;
  logic [7:0]          drop_q;
  logic                osc_rst_q, osc_halt_q, req_q;
  logic                smp_valid_q;
  logic [DATA_W-1:0]   smp_data_q;
  logic [NUM_CH-1:0]   smp_ok_q;
  logic [7:0]          smp_drops_q;
  logic                cap_en, push, halt_now;
  logic                acks_all, acks_none, ack_tmo;
  logic [SMP_W-1:0]    samples_inc;

  assign acks_all    = &ack_sync_q;
  assign acks_none   = ~|ack_sync_q;
  assign ack_tmo     = (tmr_q == TMR_W'(ACK_TIMEOUT - 1));
  assign samples_inc = samples_q + SMP_W'(1);
  assign halt_now    = (RUN_SAMPLES != 0) && (samples_inc == SMP_W'(RUN_SAMPLES));

  // Timed-out channels contribute a zero count
  always_comb begin
    cap_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ack_sync_q[i]) cap_d[i*CNT_W +: CNT_W] = osc_count[i*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q + TMR_W'(1);
    samples_d = samples_q;
    cap_en    = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (enable) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        tmr_d   = '0;
        state_d = S_GATE;
      end
      S_GATE: begin
        if (tmr_q == TMR_W'(GATE_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (acks_all || ack_tmo) begin
          tmr_d   = '0;
          cap_en  = 1'b1;
          state_d = S_REL;
        end
      end
      S_REL: begin
        if (acks_none || ack_tmo) begin
          tmr_d   = '0;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        tmr_d = '0;
        push  = 1'b1;
        if (RUN_SAMPLES != 0) samples_d = samples_inc;
        if (halt_now)    state_d = S_HALT;
        else if (enable) state_d = S_CLEAR;
        else             state_d = S_IDLE;
      end
      S_HALT: begin
        samples_d = '0;
        if (tmr_q == TMR_W'(HALT_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = enable ? S_CLEAR : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef OSC_GATE_SEQ_EN
  logic [15:0] seq_q, smp_seq_q;
  assign smp_seq = smp_seq_q;

  // Sequence advances on every push so gaps reveal dropped frames
  always_ff @(posedge ref_clk or negedge arst_n) begin
    if (!arst_n) begin
      seq_q     <= '0;
      smp_seq_q <= '0;
    end else if (push) begin
      seq_q <= seq_q + 16'd1;
      if (!smp_valid_q || smp_ready) smp_seq_q <= seq_q;
    end
  end
`endif

  always_ff @(posedge ref_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      samples_q   <= '0;
      ack_meta_q  <= '0;
      ack_sync_q  <= '0;
      cap_data_q  <= '0;
      cap_ok_q    <= '0;
      drop_q      <= '0;
      osc_rst_q   <= 1'b1;
      osc_halt_q  <= 1'b1;
      req_q       <= 1'b0;
      smp_valid_q <= 1'b0;
      smp_data_q  <= '0;
      smp_ok_q    <= '0;
      smp_drops_q <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      samples_q  <= samples_d;
      ack_meta_q <= osc_latch_ack;
      ack_sync_q <= ack_meta_q;
      osc_rst_q  <= (state_d == S_IDLE) || (state_d == S_CLEAR);
      osc_halt_q <= (state_d == S_IDLE) || (state_d == S_HALT);
      req_q      <= (state_d == S_REQ);
      if (cap_en) begin
        cap_data_q <= cap_d;
        cap_ok_q   <= ack_sync_q;
      end
      // A new frame replaces the held one only if the slot is free or being accepted now
      if (push) begin
        if (!smp_valid_q || smp_ready) begin
          smp_valid_q <= 1'b1;
          smp_data_q  <= cap_data_q;
          smp_ok_q    <= cap_ok_q;
          smp_drops_q <= drop_q;
          drop_q      <= '0;
        end else if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
      end else if (smp_valid_q && smp_ready) begin
        smp_valid_q <= 1'b0;
      end
    end
  end

  assign osc_rst       = osc_rst_q;
  assign osc_halt      = osc_halt_q;
  assign osc_latch_req = req_q;
  assign smp_valid     = smp_valid_q;
  assign smp_data      = smp_data_q;
  assign smp_ch_ok     = smp_ok_q;
  assign smp_drops     = smp_drops_q;

endmodule
